keypad_event_queue: RTL and testbench
=====================================

Name: keypad_event_queue

Overview:
- Sits directly downstream of the 4x4 keypad scanner and upstream of the typewriter character/display logic.
- Converts the scanner's intermittent key_pressed pulses and key_code into clean press events. The scanner asserts key_pressed roughly once per 4-row scan while a key is held.
- Each accepted press pushes exactly one code into a small first-word-fall-through FIFO, read out through a valid/ready handshake.
- Holding a key never repeats; releasing and pressing again produces a new event.

Parameters:
- CODE_W, 5, key code width; matches the scanner output.
- GAP_CYCLES, 8, number of consecutive key_pressed=0 samples before the key is seen as up. Must be at least 4, the scan period.
- DEBOUNCE_CYCLES, 16, stable cycles required to accept a press or a release. Must be at least 2.
- FIFO_DEPTH, 8, number of FIFO entries. Power of 2, at least 2.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, reset, asynchronous, active-low.
- key_code, input, CODE_W, code from the scanner, registered on clk.
- key_pressed, input, 1, scanner "some column active" flag.
- out_code, output, CODE_W, head-of-FIFO key code.
- out_valid, output, 1, FIFO not empty.
- out_ready, input, 1, consumer accepts out_code in a cycle where out_valid=1.
- fifo_count, output, clog2(FIFO_DEPTH)+1, occupancy.
- overflow, output, 1, sticky: a press was dropped because the FIFO was full.
- overflow_clr, input, 1, synchronous clear of overflow.

Behaviour:
- Reset (rst_n=0, async): FSM=IDLE; gap_cnt=GAP_CYCLES; stab_cnt=0; lock_code=0; cand_code=0; FIFO pointers=0; out_valid=0, out_code=0, fifo_count=0, overflow=0. Reset mid-press discards the press and clears the FIFO.
- Gap tracker, every edge:
  - If key_pressed=1: gap_cnt<=0 and cand_code<=key_code.
  - Otherwise gap_cnt<=min(gap_cnt+1, GAP_CYCLES).
  - down=(gap_cnt<GAP_CYCLES), taken from registered values.
- IDLE:
  - down=1: go to PRESS_WAIT, lock_code<=cand_code, stab_cnt<=0.
- PRESS_WAIT:
  - down=0: go to IDLE.
  - cand_code!=lock_code: lock_code<=cand_code, stab_cnt<=0, stay.
  - stab_cnt==DEBOUNCE_CYCLES-1: push lock_code, go to HELD.
  - Otherwise stab_cnt++.
- HELD:
  - cand_code!=lock_code: go to PRESS_WAIT with the new code and stab_cnt=0. This is a second key; no event yet.
  - down=0: go to RELEASE_WAIT, stab_cnt<=0.
- RELEASE_WAIT:
  - down=1 with the same code: go back to HELD; this is a bounce, no event.
  - down=1 with a different code: go to PRESS_WAIT, lock_code<=cand_code, stab_cnt<=0.
  - stab_cnt==DEBOUNCE_CYCLES-1: go to IDLE.
  - Otherwise stab_cnt++.
- Latency: take E0 as the first edge that samples key_pressed=1 from IDLE.
  - With a stable code the push occurs at edge E0+DEBOUNCE_CYCLES+1.
  - out_valid is visible after that edge (E17 with defaults).
  - There is no bypass from push to output.
- FIFO:
  - Pop happens when out_valid & out_ready.
  - out_code is the head entry, held stable while out_valid=1 and out_ready=0.
  - Push while full without a pop: the code is dropped, overflow<=1, contents unchanged.
  - Push and pop in the same cycle while full: both happen, fifo_count unchanged, no overflow.
  - Push and pop in the same cycle while empty: the push is written and the pop is ignored (out_valid was 0).
  - Pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.
- overflow_clr and a new overflow in the same cycle: overflow stays 1 (set wins).
- When out_valid=0, out_code holds its last value; there is no X.

Test Plan:
- Reset, then hold code 5'b00101 with key_pressed pulsing 1-in-4 for 40 cycles, then release -> one entry 5'b00101; out_valid rises after E17; fifo_count=1; no second entry after 100 idle cycles.
- Pulse key_pressed for 3 cycles only, then stop -> never reaches HELD; out_valid stays 0; FSM returns to IDLE.
- Hold 5'b01010, then 12 cycles of key_pressed=0, then resume for 20 cycles, then release -> exactly one entry. The 12-cycle gap exceeds GAP_CYCLES but is shorter than the release debounce, so it counts as a bounce.
- out_ready=0, perform 9 clean presses of codes 1..9 -> fifo_count=8, overflow=1, entries 1..8 retained. Then out_ready=1 -> 1..8 drain in order, out_valid drops. Then overflow_clr -> overflow=0.
- FIFO full with out_ready=1 when a new press is accepted -> push and pop in the same cycle; fifo_count stays 8; overflow stays 0; the new code is last out.
- Assert rst_n=0 mid-PRESS_WAIT with 3 entries queued -> out_valid=0 and fifo_count=0 immediately (async). After rst_n=1 with the key still held, a fresh event is accepted after the full debounce.

Source files
------------

// File: rtl/keypad_event_queue.sv
// Turns the keypad scanner's intermittent key_pressed pulses into one debounced
// press event per key stroke and queues the codes in a small FWFT FIFO.
module keypad_event_queue #(
    parameter int CODE_W          = 5,
    parameter int GAP_CYCLES      = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CODE_W-1:0]             key_code,
    input  logic                          key_pressed,
    output logic [CODE_W-1:0]             out_code,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          overflow_clr
);

    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam int STAB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(GAP_CYCLES);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    state_t              state_q, state_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [STAB_W-1:0]   stab_q, stab_d;
    logic [CODE_W-1:0]   cand_q, cand_d;
    logic [CODE_W-1:0]   lock_q, lock_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    count_after_pop;
    logic [CODE_W-1:0]   out_code_q, out_code_d;
    logic                overflow_q, overflow_d;
    logic [CODE_W-1:0]   mem_q [FIFO_DEPTH];

    logic down, push, pop, full, do_push;

    // Key counts as down until GAP_CYCLES idle samples follow the last pulse,
    // which bridges the gaps between the scanner's once-per-scan pulses.
    always_comb begin
        gap_d  = gap_q;
        cand_d = cand_q;
        if (key_pressed) begin
            gap_d  = '0;
            cand_d = key_code;
        end else if (gap_q != GAP_MAX) begin
            gap_d = gap_q + GAP_W'(1);
        end
    end

    assign down = (gap_q < GAP_MAX);

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        stab_d  = stab_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (down) begin
                    state_d = PRESS_WAIT;
                    lock_d  = cand_q;
                    stab_d  = '0;
                end
            end
            PRESS_WAIT: begin
                if (!down) begin
                    state_d = IDLE;
                end else if (cand_q != lock_q) begin
                    lock_d = cand_q;
                    stab_d = '0;
                end else if (stab_q == STAB_LAST) begin
                    push    = 1'b1;
                    state_d = HELD;
                end else begin
                    stab_d = stab_q + STAB_W'(1);
                end
            end
            HELD: begin
                if (cand_q != lock_q) begin
                    state_d = PRESS_WAIT;
                    lock_d  = cand_q;
                    stab_d  = '0;
                end else if (!down) begin
                    state_d = RELEASE_WAIT;
                    stab_d  = '0;
                end
            end
            RELEASE_WAIT: begin
                if (down) begin
                    if (cand_q == lock_q) begin
                        state_d = HELD;
                    end else begin
                        state_d = PRESS_WAIT;
                        lock_d  = cand_q;
                        stab_d  = '0;
                    end
                end else if (stab_q == STAB_LAST) begin
                    state_d = IDLE;
                end else begin
                    stab_d = stab_q + STAB_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign full            = (count_q == CNT_FULL);
    assign pop             = out_valid & out_ready;
    assign do_push         = push & (~full | pop);
    assign count_after_pop = count_q - CNT_W'(pop);

    always_comb begin
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d   = wr_ptr_q + PTR_W'(do_push);
        count_d    = count_after_pop + CNT_W'(do_push);
        overflow_d = overflow_q;
        if (push & full & ~pop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
        out_code_d = out_code_q;
        if (do_push && count_after_pop == '0) begin
            out_code_d = lock_q;
        end else if (count_d != '0) begin
            out_code_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gap_q      <= GAP_MAX;
            stab_q     <= '0;
            cand_q     <= '0;
            lock_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            out_code_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            stab_q     <= stab_d;
            cand_q     <= cand_d;
            lock_q     <= lock_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            out_code_q <= out_code_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= lock_q;
        end
    end

    assign out_code   = out_code_q;
    assign out_valid  = (count_q != '0);
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_keypad_event_queue.sv
// Directed bench for keypad_event_queue: latency, bounce handling, FIFO
// overflow, simultaneous push/pop at full and asynchronous reset mid-press.
module tb_keypad_event_queue;

    logic       clk;
    logic       rst_n;
    logic [4:0] key_code;
    logic       key_pressed;
    logic [4:0] out_code;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       overflow_clr;

    int n_cmp = 0;
    int n_err = 0;

    keypad_event_queue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_code    (key_code),
        .key_pressed (key_pressed),
        .out_code    (out_code),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .overflow_clr(overflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge; everything is driven and sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        key_pressed = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // Clean stroke: pulses 1-in-4 for 24 cycles then 30 quiet cycles.
    // Iteration i ends just after edge Ei, so the push lands at i == 17.
    task automatic do_press(input logic [4:0] code, input logic rdy_at_push);
        key_code = code;
        for (int i = 0; i < 24; i++) begin
            key_pressed = (i % 4 == 0);
            out_ready   = rdy_at_push && (i == 17);
            step();
        end
        out_ready = 1'b0;
        idle(30);
    endtask

    initial begin
        rst_n        = 1'b0;
        key_code     = '0;
        key_pressed  = 1'b0;
        out_ready    = 1'b0;
        overflow_clr = 1'b0;
        step();
        step();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_code", 32'(out_code), 0);
        rst_n = 1'b1;
        step();

        // Held key with scanner pulses: one event, visible right after E17.
        key_code = 5'b00101;
        for (int i = 0; i < 40; i++) begin
            key_pressed = (i % 4 == 0);
            step();
            if (i == 16) chk("lat_e16_valid", 32'(out_valid), 0);
            if (i == 17) begin
                chk("lat_e17_valid", 32'(out_valid), 1);
                chk("lat_e17_code", 32'(out_code), 5);
                chk("lat_e17_count", 32'(fifo_count), 1);
            end
        end
        idle(100);
        chk("hold_count", 32'(fifo_count), 1);
        chk("hold_code", 32'(out_code), 5);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pop1_valid", 32'(out_valid), 0);
        chk("pop1_count", 32'(fifo_count), 0);
        chk("pop1_code_hold", 32'(out_code), 5);

        // Three-cycle blip never debounces.
        key_code    = 5'b00011;
        key_pressed = 1'b1;
        for (int i = 0; i < 3; i++) step();
        idle(40);
        chk("blip_valid", 32'(out_valid), 0);
        chk("blip_count", 32'(fifo_count), 0);

        // Short gap during a hold is a bounce, not a new event.
        key_code = 5'b01010;
        for (int i = 0; i < 21; i++) begin
            key_pressed = (i % 4 == 0);
            step();
            if (i == 17) chk("blip_then_lat", 32'(out_valid), 1);
        end
        idle(12);
        for (int i = 0; i < 20; i++) begin
            key_pressed = (i % 4 == 0);
            step();
        end
        idle(60);
        chk("bounce_count", 32'(fifo_count), 1);
        chk("bounce_code", 32'(out_code), 10);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bounce_drain", 32'(fifo_count), 0);

        // Nine presses into an 8-deep FIFO with the consumer stalled.
        for (int k = 1; k <= 9; k++) begin
            do_press(5'(k), 1'b0);
            if (k == 8) begin
                chk("fill8_count", 32'(fifo_count), 8);
                chk("fill8_ovf", 32'(overflow), 0);
            end
        end
        chk("ovf_count", 32'(fifo_count), 8);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_head", 32'(out_code), 1);
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("drain_code_%0d", k), 32'(out_code), 32'(k));
            chk($sformatf("drain_valid_%0d", k), 32'(out_valid), 1);
            out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        chk("drained_valid", 32'(out_valid), 0);
        chk("drained_count", 32'(fifo_count), 0);
        chk("drained_code_hold", 32'(out_code), 8);
        chk("ovf_sticky", 32'(overflow), 1);
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        chk("ovf_cleared", 32'(overflow), 0);

        // Full FIFO, push and pop on the same edge.
        for (int k = 11; k <= 18; k++) do_press(5'(k), 1'b0);
        chk("full_count", 32'(fifo_count), 8);
        do_press(5'd19, 1'b1);
        chk("pp_count", 32'(fifo_count), 8);
        chk("pp_ovf", 32'(overflow), 0);
        chk("pp_head", 32'(out_code), 12);
        for (int k = 12; k <= 19; k++) begin
            chk($sformatf("pp_drain_%0d", k), 32'(out_code), 32'(k));
            out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        chk("pp_empty", 32'(out_valid), 0);

        // Asynchronous reset in the middle of a debounce with entries queued.
        do_press(5'd21, 1'b0);
        do_press(5'd22, 1'b0);
        do_press(5'd23, 1'b0);
        chk("pre_rst_count", 32'(fifo_count), 3);
        key_code = 5'd7;
        for (int i = 0; i < 6; i++) begin
            key_pressed = (i % 4 == 0);
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_count", 32'(fifo_count), 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 24; i++) begin
            key_pressed = (i % 4 == 0);
            step();
            if (i == 16) chk("post_rst_e16", 32'(out_valid), 0);
            if (i == 17) begin
                chk("post_rst_e17", 32'(out_valid), 1);
                chk("post_rst_code", 32'(out_code), 7);
                chk("post_rst_count", 32'(fifo_count), 1);
            end
        end
        idle(30);
        chk("post_rst_single", 32'(fifo_count), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
